mem_port_arbiter: RTL and testbench

//  Shares one fixed-latency single-port memory between instruction fetch (IF) and the data path (D: load/store).

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/mem_port_arbiter_pick.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the mem_port_arbiter block.
//   state_e     : access sequencer states (IDLE -> ISSUE -> WAIT -> RESP)
//   OWN_IF/OWN_D: owner encoding, IF = 0, D = 1
//   clog2       : width helper used to size the memory wait counter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: combinational owner select for the shared memory port.
//   if_req     in  fetch port requesting
//   d_req      in  data port requesting
//   last_owner in  owner of the most recent issued access
//   owner      out selected owner (OWN_IF / OWN_D); only meaningful when a req is high
// Build option MEM_ARB_RR_EN: round-robin on a tie (grant the port that was
// not last_owner). Default build: fixed D-over-IF priority, last_owner unused.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic last_owner,
    output logic owner
);

`ifdef MEM_ARB_RR_EN
    // Round-robin: on a tie the port that did not own the last access wins.
    always_comb begin
        owner = OWN_IF;
        if (if_req && d_req) begin
            owner = (last_owner == OWN_IF) ? OWN_D : OWN_IF;
        end else if (d_req) begin
            owner = OWN_D;
        end else begin
            owner = OWN_IF;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    // Fixed priority: data path always beats instruction fetch.
    always_comb begin
        owner = OWN_IF;
        if (d_req) begin
            owner = OWN_D;
        end else begin
            owner = OWN_IF;
        end
        if (!if_req && !d_req) begin
            owner = OWN_IF;
        end else begin
            owner = owner;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between
// instruction fetch (IF) and load/store (D). Each access runs
// IDLE -> ISSUE -> WAIT -> RESP; requests are sampled only in IDLE.
// Ports:
//   clk, reset                   clock, async active-high reset
//   if_req/if_addr               fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata    fetch accept pulse, response pulse, fetched word
//   d_req/d_we/d_addr/d_wdata    load/store request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata       data accept pulse, response pulse, load data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  unified memory interface
//   busy                         high whenever the sequencer is not IDLE
// Build option MEM_ARB_RR_EN selects round-robin arbitration (see mem_arb_pick).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              acc_we_q, acc_we_d;
    logic              last_owner_q, last_owner_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_gnt_q, if_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              busy_q, busy_d;
    logic              pick_owner_s;

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_owner (last_owner_q),
        .owner      (pick_owner_s)
    );

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        acc_we_d     = acc_we_q;
        last_owner_d = last_owner_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        // Strobes and pulses are single-cycle: low unless set below.
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        if_gnt_d     = 1'b0;
        d_gnt_d      = 1'b0;
        if_rvalid_d  = 1'b0;
        d_rvalid_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    // Latch the winner's access so it is on mem_* during ISSUE.
                    state_d      = ST_ISSUE;
                    owner_d      = pick_owner_s;
                    last_owner_d = pick_owner_s;
                    mem_en_d     = 1'b1;
                    if (pick_owner_s == OWN_D) begin
                        d_gnt_d     = 1'b1;
                        acc_we_d    = d_we;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        if_gnt_d    = 1'b1;
                        acc_we_d    = 1'b0;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_START;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    // mem_rdata is valid exactly now; stores leave rdata alone.
                    state_d = ST_RESP;
                    if (owner_q == OWN_D) begin
                        d_rvalid_d = 1'b1;
                        if (!acc_we_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            owner_q      <= OWN_IF;
            acc_we_q     <= 1'b0;
            last_owner_q <= OWN_IF;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_gnt_q     <= 1'b0;
            d_gnt_q      <= 1'b0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            acc_we_q     <= acc_we_d;
            last_owner_q <= last_owner_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_gnt_q     <= if_gnt_d;
            d_gnt_q      <= d_gnt_d;
            if_rvalid_q  <= if_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_gnt     = d_gnt_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a random requester model predicts
// every grant and response (cycle, owner, address, data) from the arbitration
// and timing rules; a monitor pops and compares whenever the DUT pulses.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int MEM_LAT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt, if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req, d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt, d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          port;   // 0 = IF, 1 = D
        int          cyc;
        logic [63:0] addr;
        bit          we;
        logic [63:0] wdata;
        logic [63:0] data;
    } ev_t;

    ev_t gnt_q[$];
    ev_t rsp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_default(input logic [63:0] a);
        return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
    endfunction

    // ---------------- memory responder (the "unified memory") ----------------
    logic [63:0] resp_mem [logic [63:0]];
    logic [63:0] rd_sched [int];

    always @(negedge clk) begin
        if (rd_sched.exists(cyc)) begin
            mem_rdata = rd_sched[cyc];
            rd_sched.delete(cyc);
        end else begin
            mem_rdata = {$urandom, $urandom};
        end
        if (mem_en === 1'b1) begin
            rd_sched[cyc + MEM_LAT] = resp_mem.exists(mem_addr) ? resp_mem[mem_addr] : mem_default(mem_addr);
            if (mem_we === 1'b1) resp_mem[mem_addr] = mem_wdata;
        end
    end

    // ---------------- monitor: pop and compare on every DUT pulse ----------------
    logic [63:0] mon_if_rdata = 64'd0;
    logic [63:0] mon_d_rdata  = 64'd0;

    always @(negedge clk) begin
        ev_t e;
        while (gnt_q.size() > 0 && gnt_q[0].cyc < cyc) begin
            check("gnt_missing_cycle", 64'(cyc), 64'(gnt_q[0].cyc));
            e = gnt_q.pop_front();
        end
        while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
            check("rvalid_missing_cycle", 64'(cyc), 64'(rsp_q[0].cyc));
            e = rsp_q.pop_front();
        end
        if (if_gnt || d_gnt) begin
            check("gnt_expected", 64'(gnt_q.size() != 0), 64'd1);
            if (gnt_q.size() != 0) begin
                e = gnt_q.pop_front();
                check("gnt_cycle", 64'(cyc), 64'(e.cyc));
                check("gnt_owner", {62'd0, d_gnt, if_gnt}, e.port ? 64'd2 : 64'd1);
                check("mem_en", 64'(mem_en), 64'd1);
                check("mem_we", 64'(mem_we), 64'(e.we));
                check("mem_addr", mem_addr, e.addr);
                if (e.we) check("mem_wdata", mem_wdata, e.wdata);
                check("busy", 64'(busy), 64'd1);
            end
        end else begin
            check("mem_en_idle", 64'(mem_en), 64'd0);
        end
        if (if_rvalid || d_rvalid) begin
            check("rvalid_expected", 64'(rsp_q.size() != 0), 64'd1);
            if (rsp_q.size() != 0) begin
                e = rsp_q.pop_front();
                check("rvalid_cycle", 64'(cyc), 64'(e.cyc));
                check("rvalid_owner", {62'd0, d_rvalid, if_rvalid}, e.port ? 64'd2 : 64'd1);
                if (!e.port) mon_if_rdata = e.data;
                else if (!e.we) mon_d_rdata = e.data;
                check("if_rdata", if_rdata, mon_if_rdata);
                check("d_rdata", d_rdata, mon_d_rdata);
            end
        end
    end

    // ---------------- requester + reference model ----------------
    logic [63:0] exp_mem [logic [63:0]];
    bit if_wait = 0, d_wait = 0;
    int if_gnt_at = -10, d_gnt_at = -10;
    int if_free = 0, d_free = 0;
    int next_idle = 0;
    int last_sample = -100;
    bit rr_last = 1'b0;

    function automatic logic [63:0] rand_addr();
        return 64'h100 + 64'($urandom_range(0, 7)) * 64'd8;
    endfunction

    task automatic drive_cycle(input int p_if, input int p_d);
        ev_t e;
        bit pick_d;
        @(posedge clk);
        #1;
        if (if_req && !if_wait && cyc > if_gnt_at) if_req = 1'b0;
        if (d_req && !d_wait && cyc > d_gnt_at) d_req = 1'b0;
        if (!if_req && cyc >= if_free && $urandom_range(0, 99) < p_if) begin
            if_req = 1'b1; if_addr = rand_addr(); if_wait = 1;
        end
        if (!d_req && cyc >= d_free && $urandom_range(0, 99) < p_d) begin
            d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = rand_addr();
            d_wdata = {$urandom, $urandom}; d_wait = 1;
        end
        if (cyc >= next_idle && (if_wait || d_wait)) begin
`ifdef MEM_ARB_RR_EN
            pick_d = (if_wait && d_wait) ? (rr_last == 1'b0) : d_wait;
`else
            pick_d = d_wait;
`endif
            rr_last     = pick_d;
            last_sample = cyc;
            next_idle   = cyc + MEM_LAT + 3;
            e.port = pick_d;
            e.cyc  = cyc + 1;
            if (pick_d) begin
                d_wait = 0; d_gnt_at = cyc + 1; d_free = cyc + MEM_LAT + 2;
                e.addr = d_addr; e.we = d_we; e.wdata = d_wdata;
                e.data = exp_mem.exists(d_addr) ? exp_mem[d_addr] : mem_default(d_addr);
                if (d_we) exp_mem[d_addr] = d_wdata;
            end else begin
                if_wait = 0; if_gnt_at = cyc + 1; if_free = cyc + MEM_LAT + 2;
                e.addr = if_addr; e.we = 0; e.wdata = 64'd0;
                e.data = exp_mem.exists(if_addr) ? exp_mem[if_addr] : mem_default(if_addr);
            end
            gnt_q.push_back(e);
            e.cyc = cyc + MEM_LAT + 2;
            rsp_q.push_back(e);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, {57'd0, if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy}, 64'd0);
        check({tag, "_mem_addr"}, mem_addr, 64'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        check({tag, "_if_rdata"}, if_rdata, 64'd0);
        check({tag, "_d_rdata"}, d_rdata, 64'd0);
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        if_req = 1'b0; d_req = 1'b0;
        #1;
        check_outputs_zero(tag);
        gnt_q.delete(); rsp_q.delete();
        if_wait = 0; d_wait = 0; if_free = 0; d_free = 0;
        if_gnt_at = -10; d_gnt_at = -10; rr_last = 1'b0; last_sample = -100;
        mon_if_rdata = 64'd0; mon_d_rdata = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero({tag, "_held"});
        reset = 1'b0;
        next_idle = cyc;
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        @(posedge clk);
        #1;
        apply_reset("reset");

        repeat (12) drive_cycle(100, 0);    // fetch only
        repeat (12) drive_cycle(0, 100);    // data only
        repeat (60) drive_cycle(100, 100);  // saturation: both re-raised at every RESP
        repeat (400) drive_cycle(40, 40);

        // Reset while an access sits in WAIT.
        for (int i = 0; i < 100; i++) begin
            drive_cycle(60, 60);
            if (last_sample >= 0 && cyc == last_sample + 2) break;
        end
        check("mid_reset_in_wait", 64'(cyc), 64'(last_sample + 2));
        apply_reset("mid_reset");

        repeat (400) drive_cycle(30, 60);

        for (int i = 0; i < 60; i++) begin
            if (gnt_q.size() == 0 && rsp_q.size() == 0 && !if_wait && !d_wait) break;
            drive_cycle(0, 0);
        end
        repeat (3) drive_cycle(0, 0);
        check("drain_gnt", 64'(gnt_q.size()), 64'd0);
        check("drain_rsp", 64'(rsp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
